ult_slc_frame_serializer: RTL and testbench



---
 rtl/ult_slc_frame_serializer_pkg.sv | 23 ++
 rtl/ult_slc_frame_fifo.sv | 65 ++++++
 rtl/ult_slc_frame_serializer.sv | 183 ++++++++++++++++++
 tb/tb_ult_slc_frame_serializer.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ult_slc_frame_serializer_pkg.sv
// Shared l0mdt bus constants for the SLC frame serializer slice.
// Contents:
//   SLC_RX_LEN_DEF, TTC_LEN_DEF, FLUSH_BIT_DEF : default widths / flush bit index
//   ser_state_e                                : serializer FSM states
//   sat_add16()                                : 16-bit saturating add
package ult_slc_frame_serializer_pkg;

  localparam int unsigned SLC_RX_LEN_DEF = 128;
  localparam int unsigned TTC_LEN_DEF    = 5;
  localparam int unsigned FLUSH_BIT_DEF  = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } ser_state_e;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/ult_slc_frame_fifo.sv
// Frame FIFO for the SLC serializer: one entry holds a whole BX frame.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   flush_i         : synchronous empty; overrides write and read
//   wr_en_i/wr_data_i : write request; accepted when not full, or when full
//                       with a read in the same cycle
//   rd_en_i/rd_data_o : pop request / head entry (first-word fall-through)
//   full_o, empty_o, level_o : occupancy status
module ult_slc_frame_fifo #(
  parameter int unsigned WIDTH = 384,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_wr, do_rd;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_rd   = rd_en_i && !empty_o && !flush_i;
  assign do_wr   = wr_en_i && (!full_o || do_rd) && !flush_i;

  // Pointers are AW bits wide on a power-of-two depth, so they wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign level_o   = level_q;

endmodule

// File: rtl/ult_slc_frame_serializer.sv
// Serializes BX frames of N_CAND SLC candidates into one valid/ready stream of
// the valid candidates, lowest index first.
// Optional monitor: define ULT_SLC_SER_MON_EN to build the drop counter and
// FIFO level output; otherwise both outputs read 0 (dropping is unchanged).
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   ttc_commands      : TTC bits; bit FLUSH_BIT flushes FIFO and drain
//   i_slc/i_slc_strobe: packed frame and its one-cycle strobe
//   o_slc/o_slc_valid/i_slc_ready : serialized candidate handshake
//   o_slc_idx, o_slc_last : source index / last candidate of its frame
//   o_drop_cnt, o_fifo_level : saturating drop count, stored frame count
module ult_slc_frame_serializer
  import ult_slc_frame_serializer_pkg::*;
#(
  parameter int unsigned SLC_RX_LEN  = SLC_RX_LEN_DEF,
  parameter int unsigned N_CAND      = 3,
  parameter int unsigned FRAME_DEPTH = 4,
  parameter int unsigned TTC_LEN     = TTC_LEN_DEF,
  parameter int unsigned FLUSH_BIT   = FLUSH_BIT_DEF,
  localparam int unsigned IW = (N_CAND > 1) ? $clog2(N_CAND) : 1,
  localparam int unsigned LW = $clog2(FRAME_DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [TTC_LEN-1:0]           ttc_commands,
  input  logic [SLC_RX_LEN*N_CAND-1:0] i_slc,
  input  logic                         i_slc_strobe,
  output logic [SLC_RX_LEN-1:0]        o_slc,
  output logic                         o_slc_valid,
  input  logic                         i_slc_ready,
  output logic [IW-1:0]                o_slc_idx,
  output logic                         o_slc_last,
  output logic [15:0]                  o_drop_cnt,
  output logic [LW-1:0]                o_fifo_level
);

  localparam int unsigned FW = SLC_RX_LEN * N_CAND;

  ser_state_e        state_q, state_d;
  logic [FW-1:0]     drain_q, drain_d;
  logic [N_CAND-1:0] pend_q, pend_d;

  logic [FW-1:0]     fifo_rd_data;
  logic              fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [LW-1:0]     fifo_level;
  logic [N_CAND-1:0] strobe_vmask, fifo_vmask;
  logic [IW-1:0]     cur_idx;
  logic              cur_found, cur_last, handshake, flush;

  assign flush = ttc_commands[FLUSH_BIT];

  always_comb begin
    strobe_vmask = '0;
    fifo_vmask   = '0;
    for (int unsigned k = 0; k < N_CAND; k++) begin
      strobe_vmask[k] = i_slc[k*SLC_RX_LEN + SLC_RX_LEN - 1];
      fifo_vmask[k]   = fifo_rd_data[k*SLC_RX_LEN + SLC_RX_LEN - 1];
    end
  end

  // Lowest pending index wins.
  always_comb begin
    cur_idx   = '0;
    cur_found = 1'b0;
    for (int unsigned k = 0; k < N_CAND; k++) begin
      if (pend_q[k] && !cur_found) begin
        cur_idx   = IW'(k);
        cur_found = 1'b1;
      end
    end
  end

  // Exactly one pending bit left.
  assign cur_last  = cur_found && ((pend_q & (pend_q - N_CAND'(1))) == '0);
  assign handshake = (state_q == ST_DRAIN) && i_slc_ready;

  // All-invalid frames never enter the FIFO; the FIFO itself rejects a write
  // when full unless the same edge pops.
  assign fifo_push = i_slc_strobe && (strobe_vmask != '0) && !flush;

  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    pend_d   = pend_q;
    fifo_pop = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
      pend_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) fifo_pop = 1'b1;
        end
        ST_DRAIN: begin
          if (handshake) begin
            if (cur_last) begin
              if (!fifo_empty) begin
                fifo_pop = 1'b1;
              end else begin
                state_d = ST_IDLE;
                pend_d  = '0;
              end
            end else begin
              pend_d[cur_idx] = 1'b0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
      // A pop reloads the drain register on the same edge, so a frame
      // following the last candidate of the previous one has no bubble.
      if (fifo_pop) begin
        state_d = ST_DRAIN;
        drain_d = fifo_rd_data;
        pend_d  = fifo_vmask;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      pend_q  <= pend_d;
    end
  end

  ult_slc_frame_fifo #(
    .WIDTH (FW),
    .DEPTH (FRAME_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (flush),
    .wr_en_i   (fifo_push),
    .wr_data_i (i_slc),
    .rd_en_i   (fifo_pop),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level)
  );

  assign o_slc_valid = (state_q == ST_DRAIN);
  assign o_slc       = o_slc_valid ? drain_q[cur_idx*SLC_RX_LEN +: SLC_RX_LEN] : '0;
  assign o_slc_idx   = cur_idx;
  assign o_slc_last  = o_slc_valid && cur_last;

`ifdef ULT_SLC_SER_MON_EN
  logic [15:0] drop_cnt_q;
  logic [15:0] strobe_nv;
  logic        frame_drop;
  logic        unused_ttc;

  always_comb begin
    strobe_nv = '0;
    for (int unsigned k = 0; k < N_CAND; k++) begin
      strobe_nv = strobe_nv + 16'(strobe_vmask[k]);
    end
  end

  assign frame_drop = fifo_push && fifo_full && !fifo_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             drop_cnt_q <= '0;
    else if (frame_drop) drop_cnt_q <= sat_add16(drop_cnt_q, strobe_nv);
  end

  assign o_drop_cnt   = drop_cnt_q;
  assign o_fifo_level = fifo_level;
  assign unused_ttc   = ^ttc_commands;
`else
  logic unused_mon;
  assign o_drop_cnt   = '0;
  assign o_fifo_level = '0;
  assign unused_mon   = ^{fifo_level, fifo_full, ttc_commands};
`endif

endmodule

// File: tb/tb_ult_slc_frame_serializer.sv
module tb_ult_slc_frame_serializer;

  localparam int L  = 128;
  localparam int N  = 3;
  localparam int D  = 4;
  localparam int T  = 5;
  localparam int FB = 2;
  localparam int FW = L * N;
`ifdef ULT_SLC_SER_MON_EN
  localparam bit MON = 1'b1;
`else
  localparam bit MON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [T-1:0]  ttc_commands;
  logic [FW-1:0] i_slc;
  logic          i_slc_strobe;
  logic [L-1:0]  o_slc;
  logic          o_slc_valid;
  logic          i_slc_ready;
  logic [1:0]    o_slc_idx;
  logic          o_slc_last;
  logic [15:0]   o_drop_cnt;
  logic [2:0]    o_fifo_level;

  always #5 clk = ~clk;

  ult_slc_frame_serializer #(
    .SLC_RX_LEN  (L),
    .N_CAND      (N),
    .FRAME_DEPTH (D),
    .TTC_LEN     (T),
    .FLUSH_BIT   (FB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ttc_commands (ttc_commands),
    .i_slc        (i_slc),
    .i_slc_strobe (i_slc_strobe),
    .o_slc        (o_slc),
    .o_slc_valid  (o_slc_valid),
    .i_slc_ready  (i_slc_ready),
    .o_slc_idx    (o_slc_idx),
    .o_slc_last   (o_slc_last),
    .o_drop_cnt   (o_drop_cnt),
    .o_fifo_level (o_fifo_level)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: queued frames, plus the list of candidates still to be
  // emitted from the frame being drained.
  logic [FW-1:0] m_fifo_q[$];
  logic [L-1:0]  m_word_q[$];
  int            m_idx_q[$];
  int            m_drop = 0;

  function automatic logic        e_valid(); return m_word_q.size() != 0; endfunction
  function automatic logic [L-1:0] e_word(); return (m_word_q.size() != 0) ? m_word_q[0] : '0; endfunction
  function automatic int          e_idx();   return (m_idx_q.size() != 0) ? m_idx_q[0] : 0; endfunction
  function automatic logic        e_last();  return m_word_q.size() == 1; endfunction
  function automatic int          e_level(); return MON ? m_fifo_q.size() : 0; endfunction
  function automatic int          e_drop();  return MON ? m_drop : 0; endfunction

  function automatic logic [FW-1:0] make_frame(input logic [N-1:0] vm);
    logic [FW-1:0] f;
    logic [L-1:0]  w;
    for (int k = 0; k < N; k++) begin
      w = {$urandom(), $urandom(), $urandom(), $urandom()};
      w[L-1] = vm[k];
      f[k*L +: L] = w;
    end
    return f;
  endfunction

  task automatic model_reset();
    m_fifo_q.delete();
    m_word_q.delete();
    m_idx_q.delete();
    m_drop = 0;
  endtask

  // Applies the inputs sampled at a rising edge to the model.
  task automatic model_edge();
    bit            pop, full;
    int            nv;
    logic [FW-1:0] f;
    if (rst) begin
      model_reset();
      return;
    end
    if (ttc_commands[FB]) begin
      m_fifo_q.delete();
      m_word_q.delete();
      m_idx_q.delete();
      return;
    end
    if (m_word_q.size() != 0 && i_slc_ready) begin
      void'(m_word_q.pop_front());
      void'(m_idx_q.pop_front());
    end
    full = (m_fifo_q.size() == D);
    pop  = (m_word_q.size() == 0) && (m_fifo_q.size() != 0);
    if (pop) begin
      f = m_fifo_q.pop_front();
      for (int k = 0; k < N; k++) begin
        if (f[k*L + L - 1]) begin
          m_word_q.push_back(f[k*L +: L]);
          m_idx_q.push_back(k);
        end
      end
    end
    if (i_slc_strobe) begin
      nv = 0;
      for (int k = 0; k < N; k++) nv += int'(i_slc[k*L + L - 1]);
      if (nv > 0) begin
        if (!full || pop) m_fifo_q.push_back(i_slc);
        else m_drop = (m_drop + nv > 65535) ? 65535 : m_drop + nv;
      end
    end
  endtask

  task automatic clk_edge();
    @(posedge clk);
    model_edge();
    #1;
    i_slc_strobe = 1'b0;
    ttc_commands = '0;
  endtask

  task automatic settle();
    ttc_commands = T'(1 << FB);
    i_slc_ready  = 1'b0;
    clk_edge();
    clk_edge();
  endtask

  task automatic test_reset();
    rst = 1'b1; ttc_commands = '0; i_slc = '0; i_slc_strobe = 1'b0; i_slc_ready = 1'b0;
    #2;
    n_checks++;
    if ({o_slc_valid, o_slc_last, o_slc_idx, o_slc, o_drop_cnt, o_fifo_level} !== '0)
      $display("FAIL reset_async: got v=%b l=%b i=%0d d=%0d lv=%0d want all 0",
               o_slc_valid, o_slc_last, o_slc_idx, o_drop_cnt, o_fifo_level);
    else n_pass++;
    clk_edge();
    clk_edge();
    rst = 1'b0;
    clk_edge();
    n_checks++;
    if ({o_slc_valid, o_slc_last, o_slc_idx, o_slc, o_drop_cnt, o_fifo_level} !== '0)
      $display("FAIL reset_release: got v=%b d=%0d lv=%0d want all 0",
               o_slc_valid, o_drop_cnt, o_fifo_level);
    else n_pass++;
  endtask

  task automatic test_single_frame();
    logic [FW-1:0] f;
    f = make_frame(3'b101);
    i_slc_ready = 1'b1; i_slc = f; i_slc_strobe = 1'b1;
    clk_edge();
    n_checks++;
    if (o_slc_valid !== 1'b0) $display("FAIL single_lat1: valid got %b want 0", o_slc_valid);
    else n_pass++;
    clk_edge();
    n_checks++;
    if ({o_slc_valid, o_slc_last, o_slc_idx, o_slc} !== {1'b1, 1'b0, 2'd0, f[0 +: L]})
      $display("FAIL single_idx0: got v=%b l=%b i=%0d w=%h want v=1 l=0 i=0 w=%h",
               o_slc_valid, o_slc_last, o_slc_idx, o_slc, f[0 +: L]);
    else n_pass++;
    clk_edge();
    n_checks++;
    if ({o_slc_valid, o_slc_last, o_slc_idx, o_slc} !== {1'b1, 1'b1, 2'd2, f[2*L +: L]})
      $display("FAIL single_idx2: got v=%b l=%b i=%0d w=%h want v=1 l=1 i=2 w=%h",
               o_slc_valid, o_slc_last, o_slc_idx, o_slc, f[2*L +: L]);
    else n_pass++;
    clk_edge();
    n_checks++;
    if (o_slc_valid !== 1'b0) $display("FAIL single_end: valid got %b want 0", o_slc_valid);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [FW-1:0] f;
    int code, cnt;
    f = make_frame(3'b111);
    i_slc_ready = 1'b0; i_slc = f; i_slc_strobe = 1'b1;
    clk_edge();
    clk_edge();
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if ({o_slc_valid, o_slc_last, o_slc_idx, o_slc} !== {1'b1, 1'b0, 2'd0, f[0 +: L]})
        $display("FAIL bp_hold c%0d: got v=%b l=%b i=%0d w=%h want v=1 l=0 i=0 w=%h",
                 c, o_slc_valid, o_slc_last, o_slc_idx, o_slc, f[0 +: L]);
      else n_pass++;
      clk_edge();
    end
    i_slc_ready = 1'b1;
    code = 0; cnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (o_slc_valid) begin
        code = code * 4 + int'(o_slc_idx) + 1;
        cnt++;
        n_checks++;
        if (o_slc !== f[int'(o_slc_idx)*L +: L])
          $display("FAIL bp_word idx%0d: got %h want %h", o_slc_idx, o_slc, f[int'(o_slc_idx)*L +: L]);
        else n_pass++;
      end
      clk_edge();
    end
    n_checks++;
    if (cnt !== 3 || code !== 27)
      $display("FAIL bp_stream: got count=%0d code=%0d want count=3 code=27", cnt, code);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [FW-1:0] f1, f2;
    logic [L-1:0]  ew[4];
    int            ei[4];
    logic          el[4];
    f1 = make_frame(3'b111);
    f2 = make_frame(3'b010);
    ew[0] = f1[0 +: L]; ew[1] = f1[L +: L]; ew[2] = f1[2*L +: L]; ew[3] = f2[L +: L];
    ei = '{0, 1, 2, 1};
    el = '{1'b0, 1'b0, 1'b1, 1'b1};
    i_slc_ready = 1'b1; i_slc = f1; i_slc_strobe = 1'b1;
    clk_edge();
    i_slc = f2; i_slc_strobe = 1'b1;
    clk_edge();
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if ({o_slc_valid, o_slc_last, o_slc_idx, o_slc} !== {1'b1, el[c], 2'(ei[c]), ew[c]})
        $display("FAIL b2b c%0d: got v=%b l=%b i=%0d w=%h want v=1 l=%b i=%0d w=%h",
                 c, o_slc_valid, o_slc_last, o_slc_idx, o_slc, el[c], ei[c], ew[c]);
      else n_pass++;
      clk_edge();
    end
    n_checks++;
    if (o_slc_valid !== 1'b0) $display("FAIL b2b_end: valid got %b want 0", o_slc_valid);
    else n_pass++;
  endtask

  task automatic test_overflow();
    int drop0, hs;
    drop0 = e_drop();
    i_slc_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      i_slc = make_frame(3'b111); i_slc_strobe = 1'b1;
      clk_edge();
      n_checks++;
      if ({o_fifo_level, o_drop_cnt} !== {3'(e_level()), 16'(e_drop())})
        $display("FAIL ovf_mon c%0d: got lv=%0d d=%0d want lv=%0d d=%0d",
                 c, o_fifo_level, o_drop_cnt, e_level(), e_drop());
      else n_pass++;
    end
    n_checks++;
    if ({o_fifo_level, o_drop_cnt} !== {3'(MON ? 4 : 0), 16'(drop0 + (MON ? 3 : 0))})
      $display("FAIL ovf_final: got lv=%0d d=%0d want lv=%0d d=%0d",
               o_fifo_level, o_drop_cnt, MON ? 4 : 0, drop0 + (MON ? 3 : 0));
    else n_pass++;
    i_slc_ready = 1'b1;
    hs = 0;
    for (int c = 0; c < 25; c++) begin
      if (o_slc_valid) hs++;
      clk_edge();
      n_checks++;
      if (e_valid()) begin
        if ({o_slc_valid, o_slc_last, o_slc_idx, o_slc} !== {1'b1, e_last(), 2'(e_idx()), e_word()})
          $display("FAIL ovf_drain c%0d: got v=%b l=%b i=%0d w=%h want v=1 l=%b i=%0d w=%h",
                   c, o_slc_valid, o_slc_last, o_slc_idx, o_slc, e_last(), e_idx(), e_word());
        else n_pass++;
      end else begin
        if (o_slc_valid !== 1'b0) $display("FAIL ovf_drain c%0d: valid got %b want 0", c, o_slc_valid);
        else n_pass++;
      end
    end
    n_checks++;
    if (hs !== 15) $display("FAIL ovf_count: accepted got %0d want 15", hs);
    else n_pass++;
  endtask

  task automatic test_flush();
    int drop0;
    i_slc_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      i_slc = make_frame(3'b111); i_slc_strobe = 1'b1;
      clk_edge();
    end
    n_checks++;
    if ({o_slc_valid, o_fifo_level} !== {1'b1, 3'(MON ? 2 : 0)})
      $display("FAIL flush_pre: got v=%b lv=%0d want v=1 lv=%0d", o_slc_valid, o_fifo_level, MON ? 2 : 0);
    else n_pass++;
    drop0 = e_drop();
    ttc_commands = T'(1 << FB);
    i_slc = make_frame(3'b011); i_slc_strobe = 1'b1;
    clk_edge();
    n_checks++;
    if ({o_slc_valid, o_fifo_level, o_drop_cnt} !== {1'b0, 3'd0, 16'(drop0)})
      $display("FAIL flush_post: got v=%b lv=%0d d=%0d want v=0 lv=0 d=%0d",
               o_slc_valid, o_fifo_level, o_drop_cnt, drop0);
    else n_pass++;
    for (int c = 0; c < 3; c++) begin
      clk_edge();
      n_checks++;
      if (o_slc_valid !== 1'b0) $display("FAIL flush_discard c%0d: valid got %b want 0", c, o_slc_valid);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [FW-1:0] f3;
    i_slc_ready = 1'b0;
    i_slc = make_frame(3'b111); i_slc_strobe = 1'b1;
    clk_edge();
    i_slc = make_frame(3'b110); i_slc_strobe = 1'b1;
    clk_edge();
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({o_slc_valid, o_slc_last, o_slc_idx, o_slc, o_drop_cnt, o_fifo_level} !== '0)
      $display("FAIL rst_mid: got v=%b l=%b i=%0d lv=%0d want all 0",
               o_slc_valid, o_slc_last, o_slc_idx, o_fifo_level);
    else n_pass++;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    f3 = make_frame(3'b011);
    i_slc = f3; i_slc_strobe = 1'b1; i_slc_ready = 1'b1;
    clk_edge();
    clk_edge();
    n_checks++;
    if ({o_slc_valid, o_slc_last, o_slc_idx, o_slc} !== {1'b1, 1'b0, 2'd0, f3[0 +: L]})
      $display("FAIL rst_resume: got v=%b l=%b i=%0d w=%h want v=1 l=0 i=0 w=%h",
               o_slc_valid, o_slc_last, o_slc_idx, o_slc, f3[0 +: L]);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      i_slc        = make_frame(3'($urandom_range(7)));
      i_slc_strobe = ($urandom_range(2) == 0);
      i_slc_ready  = ($urandom_range(3) != 0);
      ttc_commands = T'($urandom()) & ~T'(1 << FB);
      if ($urandom_range(59) == 0) ttc_commands[FB] = 1'b1;
      clk_edge();
      n_checks++;
      if (e_valid()) begin
        if ({o_slc_valid, o_slc_last, o_slc_idx, o_slc} !== {1'b1, e_last(), 2'(e_idx()), e_word()})
          $display("FAIL rand_out c%0d: got v=%b l=%b i=%0d w=%h want v=1 l=%b i=%0d w=%h",
                   c, o_slc_valid, o_slc_last, o_slc_idx, o_slc, e_last(), e_idx(), e_word());
        else n_pass++;
      end else begin
        if (o_slc_valid !== 1'b0) $display("FAIL rand_out c%0d: valid got %b want 0", c, o_slc_valid);
        else n_pass++;
      end
      n_checks++;
      if ({o_fifo_level, o_drop_cnt} !== {3'(e_level()), 16'(e_drop())})
        $display("FAIL rand_mon c%0d: got lv=%0d d=%0d want lv=%0d d=%0d",
                 c, o_fifo_level, o_drop_cnt, e_level(), e_drop());
      else n_pass++;
    end
  endtask

  task automatic test_saturation();
    i_slc_ready = 1'b0;
    for (int c = 0; c < 21860; c++) begin
      i_slc = make_frame(3'b111); i_slc_strobe = 1'b1;
      clk_edge();
    end
    n_checks++;
    if (o_drop_cnt !== 16'(MON ? 16'hFFFF : 0) || o_drop_cnt !== 16'(e_drop()))
      $display("FAIL sat_reach: got %0d want %0d", o_drop_cnt, MON ? 65535 : 0);
    else n_pass++;
    for (int c = 0; c < 5; c++) begin
      i_slc = make_frame(3'b111); i_slc_strobe = 1'b1;
      clk_edge();
    end
    n_checks++;
    if (o_drop_cnt !== 16'(MON ? 16'hFFFF : 0))
      $display("FAIL sat_hold: got %0d want %0d", o_drop_cnt, MON ? 65535 : 0);
    else n_pass++;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_frame();
    settle();
    test_backpressure();
    settle();
    test_back_to_back();
    settle();
    test_overflow();
    settle();
    test_flush();
    settle();
    test_reset_mid_drain();
    settle();
    test_random();
    settle();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
